prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 24 ++
 rtl/prog_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream loader bus: upstream valid/ready byte channel plus program-memory write port and status.
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_run;
  logic              err;
  logic [ADDR_W:0]   word_count;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_run, err, word_count
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_run, err, word_count
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a length-prefixed, XOR-checksummed word stream into program memory, then releases the CPU.
// Write strobe one cycle after the low byte; rx_ready drops for good once the load succeeds or fails.
module prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LEN_HI  = 3'd0,
    S_LEN_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_CHK     = 3'd4,
    S_RUN     = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  state_e            state_q, state_d;
  logic              out_en_q;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic              rdy;
  logic              run;
  logic              fail;
  logic              accept;
  logic [15:0]       len_rx;
  logic              len_bad;
  logic              last_word;

  assign accept    = bus.rx_valid & rdy;
  assign len_rx    = {len_q[15:8], bus.rx_data};
  assign len_bad   = (len_rx == 16'd0) || (32'(len_rx) > MAX_N);
  assign last_word = (32'(cnt_q) + 32'd1) == 32'(len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LEN_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        S_LEN_HI:  state_d = S_LEN_LO;
        S_LEN_LO:  state_d = len_bad ? S_ERR : S_DATA_HI;
        S_DATA_HI: state_d = S_DATA_LO;
        S_DATA_LO: state_d = last_word ? S_CHK : S_DATA_HI;
        S_CHK:     state_d = (bus.rx_data == csum_q) ? S_RUN : S_ERR;
        default:   state_d = state_q;
      endcase
    end
  end

  // out_en_q keeps rx_ready low until the first edge after reset release
  always_comb begin
    rdy  = 1'b0;
    run  = 1'b0;
    fail = 1'b0;
    unique case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK: rdy = out_en_q;
      S_RUN:   run  = 1'b1;
      S_ERR:   fail = 1'b1;
      default: rdy  = 1'b0;
    endcase
  end

  always_comb begin
    len_d    = len_q;
    hi_d     = hi_q;
    csum_d   = csum_q;
    mem_we_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    if (accept) begin
      unique case (state_q)
        S_LEN_HI: begin
          len_d[15:8] = bus.rx_data;
          csum_d      = csum_q ^ bus.rx_data;
        end
        S_LEN_LO: begin
          len_d[7:0] = bus.rx_data;
          csum_d     = csum_q ^ bus.rx_data;
        end
        S_DATA_HI: begin
          hi_d   = bus.rx_data;
          csum_d = csum_q ^ bus.rx_data;
        end
        S_DATA_LO: begin
          mem_we_d = 1'b1;
          addr_d   = cnt_q[ADDR_W-1:0];
          wdata_d  = {hi_q, bus.rx_data};
          cnt_d    = cnt_q + (ADDR_W+1)'(1);
          csum_d   = csum_q ^ bus.rx_data;
        end
        default: begin
          csum_d = csum_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en_q <= 1'b0;
      len_q    <= '0;
      hi_q     <= '0;
      csum_q   <= '0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      out_en_q <= 1'b1;
      len_q    <= len_d;
      hi_q     <= hi_d;
      csum_q   <= csum_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.rx_ready   = rdy;
  assign bus.cpu_run    = run;
  assign bus.err        = fail;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.word_count = cnt_q;

endmodule
